bram_rd_arbiter: RTL and testbench

BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

---
 rtl/bram_rd_arbiter_pkg.sv | 19 +
 rtl/bram_rd_arbiter_pick.sv | 40 ++++
 rtl/bram_rd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bram_rd_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bram_rd_arbiter_pkg
// Shared definitions for the BRAM read arbiter slice:
//   BRAM_AW / BRAM_DW : default BRAM read address / data widths
//   arb_state_t       : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package bram_rd_arbiter_pkg;

  localparam int BRAM_AW = 13;
  localparam int BRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_HOLD    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/bram_rd_arbiter_pick.sv
// ---------------------------------------------------------------------------
// bram_rd_arb_pick
// Combinational winner picker. The lowest-index requesting bit at or above
// ptr wins, wrapping around past NREQ-1 back to 0.
// Ports:
//   req [NREQ-1:0] : request bits
//   ptr [PW-1:0]   : search start index
//   gnt [NREQ-1:0] : one-hot winner (zero when no request)
//   idx [PW-1:0]   : winner index (zero when no request)
//   any            : at least one request present
// ---------------------------------------------------------------------------
module bram_rd_arb_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Outer loop walks the search order starting at ptr; the inner loop only
  // exists so every bit select uses a loop constant.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any && req[j] && (j == (int'(ptr) + off) % NREQ)) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// bram_rd_arbiter
// Shares one BRAM read controller between NREQ level-triggered requesters.
// One transaction at a time: IDLE picks a winner, ISSUE holds the bus
// trigger until the controller reports done, RELEASE waits for done to
// drop, HOLD presents o_req_done to the owner until it drops its trigger.
//
// Build option: define BRAM_RD_ARB_RR_EN for round-robin winner selection;
// without it the arbiter uses fixed priority (index 0 highest).
//
// Ports:
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_req_trig     : per-requester level trigger
//   i_req_addr     : packed per-requester addresses, slice k = [k*AW +: AW]
//   o_req_done     : per-requester done (only the owner's bit can be high)
//   o_rd_data      : last read data, valid while any o_req_done bit is high
//   o_grant        : one-hot current owner, zero when idle
//   o_busy         : arbiter not idle
//   o_bram_addr    : address to the BRAM read controller
//   o_bram_trig    : level trigger to the BRAM read controller
//   i_bram_data    : read data from the controller
//   i_bram_done    : controller done (level)
// ---------------------------------------------------------------------------
module bram_rd_arbiter
  import bram_rd_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = BRAM_AW,
  parameter int DW   = BRAM_DW
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [NREQ-1:0]    i_req_trig,
  input  logic [NREQ*AW-1:0] i_req_addr,
  output logic [NREQ-1:0]    o_req_done,
  output logic [DW-1:0]      o_rd_data,
  output logic [NREQ-1:0]    o_grant,
  output logic               o_busy,
  output logic [AW-1:0]      o_bram_addr,
  output logic               o_bram_trig,
  input  logic [DW-1:0]      i_bram_data,
  input  logic               i_bram_done
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [AW-1:0]   addr_nxt;
  logic            trig_nxt;
  logic [DW-1:0]   rd_nxt;
  logic            done_pre, done_pre_nxt;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [AW-1:0]   win_addr;
  logic            owner_trig;

`ifdef BRAM_RD_ARB_RR_EN
  logic [PW-1:0] ptr, ptr_nxt;

  // Advance past the owner whenever a transaction ends (HOLD->IDLE or an
  // aborted RELEASE->IDLE); o_grant still names the owner at that point.
  always_comb begin
    ptr_nxt = ptr;
    if (state != ST_IDLE && state_nxt == ST_IDLE) begin
      for (int j = 0; j < NREQ; j++) begin
        if (o_grant[j]) ptr_nxt = (j == NREQ - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr <= '0;
    else         ptr <= ptr_nxt;
  end
`else
  logic [PW-1:0] ptr;
  assign ptr = '0;
`endif

  bram_rd_arb_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (i_req_trig),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    win_addr = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (PW'(j) == pick_idx) win_addr = i_req_addr[j*AW +: AW];
    end
  end

  // o_grant is one-hot, so masking picks out the owner's own trigger.
  assign owner_trig = |(i_req_trig & o_grant);
  assign o_req_done = {NREQ{done_pre}} & o_grant & i_req_trig;
  assign o_busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = o_grant;
    addr_nxt     = o_bram_addr;
    trig_nxt     = o_bram_trig;
    rd_nxt       = o_rd_data;
    done_pre_nxt = done_pre;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_ISSUE;
          grant_nxt = pick_gnt;
          addr_nxt  = win_addr;
          trig_nxt  = 1'b1;
        end
      end
      // The owner may drop its trigger here; the bus read still completes.
      ST_ISSUE: begin
        if (i_bram_done) begin
          state_nxt = ST_RELEASE;
          rd_nxt    = i_bram_data;
          trig_nxt  = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (!i_bram_done) begin
          if (owner_trig) begin
            state_nxt    = ST_HOLD;
            done_pre_nxt = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
          end
        end
      end
      ST_HOLD: begin
        if (!owner_trig) begin
          state_nxt    = ST_IDLE;
          done_pre_nxt = 1'b0;
          grant_nxt    = '0;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        grant_nxt    = '0;
        trig_nxt     = 1'b0;
        done_pre_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Asynchronous reset drops the bus trigger at once, without waiting for
  // the controller to finish an outstanding read.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_grant     <= '0;
      o_bram_addr <= '0;
      o_bram_trig <= 1'b0;
      o_rd_data   <= '0;
      done_pre    <= 1'b0;
    end else begin
      o_grant     <= grant_nxt;
      o_bram_addr <= addr_nxt;
      o_bram_trig <= trig_nxt;
      o_rd_data   <= rd_nxt;
      done_pre    <= done_pre_nxt;
    end
  end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_rd_arbiter
// Self-checking bench for bram_rd_arbiter (NREQ=2). A transaction-level
// model follows each request through pick / bus read / bus release / done
// handshake and every DUT output is compared against it once per cycle.
// Directed scenarios add literal expectations. Honours BRAM_RD_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_bram_rd_arbiter;

  localparam int NREQ     = 2;
  localparam int AW       = 13;
  localparam int DW       = 32;
  localparam int BRAM_LAT = 4;
  localparam logic [AW-1:0] ADDR0 = 13'h0100;
  localparam logic [AW-1:0] ADDR1 = 13'h0A55;

  logic               i_clk = 1'b0;
  logic               i_rstn;
  logic [NREQ-1:0]    trig;
  logic [NREQ*AW-1:0] addrs;
  logic [NREQ-1:0]    o_req_done;
  logic [DW-1:0]      o_rd_data;
  logic [NREQ-1:0]    o_grant;
  logic               o_busy;
  logic [AW-1:0]      o_bram_addr;
  logic               o_bram_trig;
  logic [DW-1:0]      bram_data;
  logic               bram_done;

  always #5 i_clk = ~i_clk;

  bram_rd_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req_trig  (trig),
    .i_req_addr  (addrs),
    .o_req_done  (o_req_done),
    .o_rd_data   (o_rd_data),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_bram_addr (o_bram_addr),
    .o_bram_trig (o_bram_trig),
    .i_bram_data (bram_data),
    .i_bram_done (bram_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- transaction model ----------------
  // phase: 0 no owner, 1 bus read outstanding, 2 waiting for bus done to
  // fall, 3 owner handshake
  int            m_own = -1;
  int            m_ph = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_rd = '0;

  function automatic int pick_model(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic int next_ptr(input int own);
`ifdef BRAM_RD_ARB_RR_EN
    return (own + 1) % NREQ;
`else
    return 0;
`endif
  endfunction

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_own <= -1; m_ph <= 0; m_ptr <= 0; m_addr <= '0; m_rd <= '0;
    end else begin
      case (m_ph)
        0: if (trig != '0) begin
             m_own  <= pick_model(trig, m_ptr);
             m_addr <= addrs[pick_model(trig, m_ptr)*AW +: AW];
             m_ph   <= 1;
           end
        1: if (bram_done) begin
             m_rd <= bram_data;
             m_ph <= 2;
           end
        2: if (!bram_done) begin
             if (trig[m_own]) m_ph <= 3;
             else begin m_ph <= 0; m_own <= -1; m_ptr <= next_ptr(m_own); end
           end
        3: if (!trig[m_own]) begin
             m_ph <= 0; m_own <= -1; m_ptr <= next_ptr(m_own);
           end
        default: m_ph <= 0;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [NREQ-1:0] eg, ed;
    eg = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
    ed = (m_ph == 3 && m_own >= 0 && trig[m_own]) ? eg : '0;
    chk("m_grant", o_grant, eg);
    chk("m_busy", o_busy, (m_own >= 0));
    chk("m_bram_trig", o_bram_trig, (m_ph == 1));
    chk("m_bram_addr", o_bram_addr, m_addr);
    chk("m_rd_data", o_rd_data, m_rd);
    chk("m_req_done", o_req_done, ed);
  endtask

  // ---------------- stimulus state ----------------
  logic [DW-1:0]   bram_word;
  int              bram_cnt;
  bit              auto_en;
  int              rem [NREQ];
  logic [NREQ-1:0] prev_gnt;
  int              glog[$];
  logic [AW-1:0]   alog[$];
  int              exp_g [6];

  // One clock: drive at posedge+2 (BRAM responder, automatic requesters),
  // compare against the model on the falling edge.
  task automatic step();
    @(posedge i_clk);
    #2;
    if (!o_bram_trig) begin
      bram_done = 1'b0;
      bram_cnt  = 0;
    end else if (!bram_done) begin
      if (bram_cnt == BRAM_LAT - 1) begin
        bram_done = 1'b1;
        bram_data = bram_word;
        bram_word = bram_word + 1;
      end else begin
        bram_cnt++;
      end
    end
    if (auto_en) begin
      for (int k = 0; k < NREQ; k++) begin
        if (trig[k]) begin
          if (o_req_done[k]) trig[k] = 1'b0;
        end else if (rem[k] > 0) begin
          trig[k] = 1'b1;
          rem[k]--;
        end
      end
    end
    @(negedge i_clk);
    cmp_model();
    if (o_grant != '0 && prev_gnt == '0) begin
      glog.push_back(o_grant[1] ? 1 : 0);
      alog.push_back(o_bram_addr);
    end
    prev_gnt = o_grant;
  endtask

  initial begin
    bit seen_done0;
    trig = '0; addrs = {ADDR1, ADDR0};
    bram_done = 1'b0; bram_data = '0; bram_word = 32'hA5A5_0000; bram_cnt = 0;
    auto_en = 1'b0; rem[0] = 0; rem[1] = 0; prev_gnt = '0;
`ifdef BRAM_RD_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 1, 1, 1};
`endif
    i_rstn = 1'b0;
    repeat (3) step();
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_bram_trig", o_bram_trig, 0);
    chk("rst_bram_addr", o_bram_addr, 0);
    i_rstn = 1'b1;
    step();

    // Single request, then owner holds its trigger 5 cycles after done
    bram_word = 32'hDEAD_BEEF;
    trig[0] = 1'b1;
    step();
    chk("A_trig_latency", o_bram_trig, 1);
    for (int c = 0; c < 30 && !o_req_done[0]; c++) step();
    chk("A_done_timeout", o_req_done[0], 1);
    chk("A_bram_addr", o_bram_addr, ADDR0);
    chk("A_rd_data", o_rd_data, 32'hDEAD_BEEF);
    chk("A_done_vec", o_req_done, 2'b01);
    chk("A_grant", o_grant, 2'b01);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("D_done_held", o_req_done, 2'b01);
    end
    trig[0] = 1'b0;
    #1;
    chk("D_done_drop", o_req_done, 2'b00);
    repeat (3) step();
    chk("D_rd_hold", o_rd_data, 32'hDEAD_BEEF);
    chk("D_idle_grant", o_grant, 0);

    // Both requesters, three requests each, re-asserting right after done
    glog.delete(); alog.delete(); prev_gnt = o_grant;
    rem[0] = 2; rem[1] = 2; trig = 2'b11; auto_en = 1'b1;
    for (int c = 0; c < 400 && !(rem[0] == 0 && rem[1] == 0 && trig == '0 && !o_busy); c++) step();
    auto_en = 1'b0;
    chk("B_timeout", (rem[0] == 0 && rem[1] == 0 && trig == '0 && !o_busy), 1);
    chk("B_grant_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("B_grant_order", (i < glog.size()) ? glog[i] : -1, exp_g[i]);
      chk("B_grant_addr", (i < alog.size()) ? alog[i] : '1, (exp_g[i] == 0) ? ADDR0 : ADDR1);
    end

    // Owner abort during the bus read, pending req1 served afterwards
    trig = 2'b11;
    for (int c = 0; c < 20 && !o_bram_trig; c++) step();
    chk("C_issue_timeout", o_bram_trig, 1);
    chk("C_owner", o_grant, 2'b01);
    repeat (2) step();
    trig[0] = 1'b0;
    seen_done0 = 1'b0;
    for (int c = 0; c < 40 && o_grant != 2'b10; c++) begin
      step();
      if (o_req_done[0]) seen_done0 = 1'b1;
    end
    chk("C_no_done0", seen_done0, 0);
    chk("C_next_owner", o_grant, 2'b10);
    chk("C_next_addr", o_bram_addr, ADDR1);
    for (int c = 0; c < 30 && !o_req_done[1]; c++) step();
    chk("C_done1_timeout", o_req_done, 2'b10);
    trig[1] = 1'b0;
    repeat (2) step();
    chk("C_idle", o_busy, 0);

    // Reset pulse during the bus read
    trig[0] = 1'b1;
    for (int c = 0; c < 20 && !o_bram_trig; c++) step();
    chk("E_issue_timeout", o_bram_trig, 1);
    step();
    i_rstn = 1'b0;
    #1;
    chk("E_rst_trig", o_bram_trig, 0);
    chk("E_rst_grant", o_grant, 0);
    chk("E_rst_busy", o_busy, 0);
    trig = '0;
    repeat (2) step();
    i_rstn = 1'b1;
    bram_word = 32'h1234_5678;
    trig[1] = 1'b1;
    for (int c = 0; c < 30 && !o_req_done[1]; c++) step();
    chk("E_done_timeout", o_req_done, 2'b10);
    chk("E_rd_data", o_rd_data, 32'h1234_5678);
    chk("E_bram_addr", o_bram_addr, ADDR1);
    trig[1] = 1'b0;
    repeat (2) step();
    chk("E_final_idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
